banco_registradores_sb: RTL and testbench

//  Parametrised register file with N combinational read ports, one write port and a
//  per-register busy scoreboard. Replaces the fixed 32x32 file: adds reset, write enable,

---
 rtl/banco_registradores_sb_if.sv | 28 ++
 rtl/banco_registradores_sb.sv | 76 +++++++
 tb/tb_banco_registradores_sb.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/banco_registradores_sb_if.sv
// Bus between the register file and its user: one write port, NUM_READ read ports
// and the scoreboard claim/busy signals.
interface banco_registradores_sb_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic [NUM_READ*ADDR_W-1:0] rd_addr;
  logic [NUM_READ*DATA_W-1:0] rd_data;
  logic [NUM_READ-1:0]        rd_busy;
  logic                       claim_en;
  logic [ADDR_W-1:0]          claim_addr;
  logic                       claim_ok;
  logic [(2**ADDR_W)-1:0]     busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, claim_en, claim_addr,
    input  rd_data, rd_busy, claim_ok, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, claim_en, claim_addr,
    output rd_data, rd_busy, claim_ok, busy_vec
  );
endinterface

// File: rtl/banco_registradores_sb.sv
// Parametrised register file: NUM_READ combinational read ports, one write port,
// optional hard-wired zero register, write->read bypass and a per-register busy scoreboard.
module banco_registradores_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic                     clock,
  input logic                     reset,
  banco_registradores_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_fire;
  logic              claim_free;
  logic              claim_ok;
  logic              claim_set;

  // Write and claim qualification; register 0 absorbs both when hard-wired to zero.
  always_comb begin
    wr_fire    = bus.wr_en && !(ZERO_REG && bus.wr_addr == '0);
    claim_free = !busy_q[bus.claim_addr] ||
                 (bus.wr_en && bus.wr_addr == bus.claim_addr);
    claim_ok   = bus.claim_en && claim_free && !reset;
    claim_set  = claim_ok && !(ZERO_REG && bus.claim_addr == '0);
  end

  always_comb begin
    // NOTE: default assigned first so every path drives busy_d and no latch is inferred.
    busy_d = busy_q;
    if (wr_fire)   busy_d[bus.wr_addr]    = 1'b0;
    if (claim_set) busy_d[bus.claim_addr] = 1'b1;  // set after clear: new owner wins
  end

  // NOTE: the storage array is reset to zero, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      busy_q <= '0;
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
    end else begin
      busy_q <= busy_d;
      if (wr_fire) regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  logic [ADDR_W-1:0] rd_a;
  logic              rd_zero;
  logic              rd_byp;

  // Each read port resolves independently; zero register beats bypass.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    rd_a        = '0;
    rd_zero     = 1'b0;
    rd_byp      = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      rd_a    = bus.rd_addr[i*ADDR_W +: ADDR_W];
      rd_zero = ZERO_REG && rd_a == '0;
      rd_byp  = BYPASS && bus.wr_en && bus.wr_addr == rd_a;
      if (!reset && !rd_zero) begin
        bus.rd_data[i*DATA_W +: DATA_W] = rd_byp ? bus.wr_data : regs_q[rd_a];
        bus.rd_busy[i]                  = !rd_byp && busy_q[rd_a];
      end
    end
  end

  assign bus.claim_ok = claim_ok;
  assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_banco_registradores_sb.sv
// Directed bench: vector table on the default configuration plus hand-written sequences
// for reset, scoreboard, collision, bypass-off, zero-register-off and a narrow 3-port build.
module tb_banco_registradores_sb;
  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;

  banco_registradores_sb_if                                          m_if ();
  banco_registradores_sb_if                                          nb_if ();
  banco_registradores_sb_if                                          nz_if ();
  banco_registradores_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_READ(3)) s_if ();

  banco_registradores_sb u_main (.clock(clock), .reset(reset), .bus(m_if.slave));
  banco_registradores_sb #(.BYPASS(1'b0))   u_nobyp  (.clock(clock), .reset(reset), .bus(nb_if.slave));
  banco_registradores_sb #(.ZERO_REG(1'b0)) u_nozero (.clock(clock), .reset(reset), .bus(nz_if.slave));
  banco_registradores_sb #(.DATA_W(16), .ADDR_W(3), .NUM_READ(3))
    u_small (.clock(clock), .reset(reset), .bus(s_if.slave));

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
    logic [1:0]  exp_busy;
    logic        exp_ok;
    logic [31:0] exp_vec;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_m(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic ce, input logic [4:0] ca);
    m_if.wr_en      = we;
    m_if.wr_addr    = wa;
    m_if.wr_data    = wd;
    m_if.rd_addr    = {r1, r0};
    m_if.claim_en   = ce;
    m_if.claim_addr = ca;
  endtask

  task automatic idle_all();
    drive_m(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    nb_if.wr_en = 1'b0; nb_if.wr_addr = '0; nb_if.wr_data = '0;
    nb_if.rd_addr = '0; nb_if.claim_en = 1'b0; nb_if.claim_addr = '0;
    nz_if.wr_en = 1'b0; nz_if.wr_addr = '0; nz_if.wr_data = '0;
    nz_if.rd_addr = '0; nz_if.claim_en = 1'b0; nz_if.claim_addr = '0;
    s_if.wr_en = 1'b0; s_if.wr_addr = '0; s_if.wr_data = '0;
    s_if.rd_addr = '0; s_if.claim_en = 1'b0; s_if.claim_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          we    wa     wd             rd0    rd1    ce    ca     exp_rd0        exp_rd1   busy   ok    vec
    tbl[0]  = '{1'b1, 5'd1,  32'h0000_0011, 5'd1,  5'd2,  1'b0, 5'd0,  32'h0000_0011, 32'h0,    2'b00, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 5'd2,  32'h0000_0022, 5'd1,  5'd2,  1'b0, 5'd0,  32'h0000_0011, 32'h22,   2'b00, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd1,  1'b1, 5'd1,  32'h0000_0011, 32'h11,   2'b00, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd2,  1'b1, 5'd2,  32'h0000_0011, 32'h22,   2'b01, 1'b1, 32'h2};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,         5'd2,  5'd1,  1'b1, 5'd1,  32'h0000_0022, 32'h11,   2'b11, 1'b0, 32'h6};
    tbl[5]  = '{1'b1, 5'd1,  32'h0000_00AA, 5'd1,  5'd2,  1'b0, 5'd0,  32'h0000_00AA, 32'h22,   2'b10, 1'b0, 32'h6};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd2,  1'b0, 5'd0,  32'h0000_00AA, 32'h22,   2'b10, 1'b0, 32'h4};
    tbl[7]  = '{1'b1, 5'd0,  32'h0000_FFFF, 5'd0,  5'd0,  1'b1, 5'd0,  32'h0,         32'h0,    2'b00, 1'b1, 32'h4};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd31, 1'b0, 5'd0,  32'h0,         32'h0,    2'b00, 1'b0, 32'h4};
    tbl[9]  = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd30, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0,    2'b00, 1'b1, 32'h4};
    tbl[10] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd2,  1'b0, 5'd0,  32'hFFFF_FFFF, 32'h22,   2'b11, 1'b0, 32'h8000_0004};

    idle_all();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset: fill state, then pulse reset with a claim pending.
    drive_m(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b1, 5'd7);
    settle();
    check("pre_reset claim_ok", m_if.claim_ok, 1'b1);
    tick();
    drive_m(1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 1'b0, 5'd0);
    settle();
    check("pre_reset rd_data", m_if.rd_data, {32'h0, 32'hDEAD_BEEF});
    check("pre_reset rd_busy", m_if.rd_busy, 2'b10);
    check("pre_reset busy_vec", m_if.busy_vec, 32'h80);
    reset = 1'b1;
    drive_m(1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 1'b1, 5'd8);
    settle();
    check("in_reset rd_data", m_if.rd_data, 64'h0);
    check("in_reset rd_busy", m_if.rd_busy, 2'b00);
    check("in_reset claim_ok", m_if.claim_ok, 1'b0);
    check("in_reset busy_vec stored", m_if.busy_vec, 32'h80);
    tick();
    check("in_reset busy_vec cleared", m_if.busy_vec, 32'h0);
    reset = 1'b0;
    drive_m(1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 1'b0, 5'd0);
    settle();
    check("post_reset rd_data", m_if.rd_data, 64'h0);
    check("post_reset busy_vec", m_if.busy_vec, 32'h0);

    // Table-driven vectors on the default build.
    for (int i = 0; i < 11; i++) begin
      drive_m(tbl[i].wr_en, tbl[i].wr_addr, tbl[i].wr_data, tbl[i].rd0, tbl[i].rd1,
              tbl[i].claim_en, tbl[i].claim_addr);
      settle();
      check($sformatf("vec%0d rd_data", i), m_if.rd_data, {tbl[i].exp_rd1, tbl[i].exp_rd0});
      check($sformatf("vec%0d rd_busy", i), m_if.rd_busy, tbl[i].exp_busy);
      check($sformatf("vec%0d claim_ok", i), m_if.claim_ok, tbl[i].exp_ok);
      check($sformatf("vec%0d busy_vec", i), m_if.busy_vec, tbl[i].exp_vec);
      tick();
    end

    // Scoreboard on r4: claim, refused re-claim, write clears.
    drive_m(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b1, 5'd4);
    settle();
    check("sb first claim_ok", m_if.claim_ok, 1'b1);
    tick();
    drive_m(1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b1, 5'd4);
    settle();
    check("sb second claim_ok", m_if.claim_ok, 1'b0);
    check("sb rd_busy", m_if.rd_busy, 2'b01);
    check("sb busy_vec4 set", m_if.busy_vec[4], 1'b1);
    tick();
    drive_m(1'b1, 5'd4, 32'd9, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    drive_m(1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0);
    settle();
    check("sb write rd_data", m_if.rd_data, {32'h0, 32'd9});
    check("sb write rd_busy", m_if.rd_busy, 2'b00);
    check("sb busy_vec4 clear", m_if.busy_vec[4], 1'b0);

    // Collision on r6: write and claim the busy register together.
    drive_m(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd6);
    tick();
    drive_m(1'b1, 5'd6, 32'h55, 5'd6, 5'd0, 1'b1, 5'd6);
    settle();
    check("coll claim_ok", m_if.claim_ok, 1'b1);
    check("coll bypass rd_data", m_if.rd_data[31:0], 32'h55);
    tick();
    drive_m(1'b0, 5'd0, 32'h0, 5'd6, 5'd0, 1'b0, 5'd0);
    settle();
    check("coll rd_data", m_if.rd_data[31:0], 32'h55);
    check("coll rd_busy", m_if.rd_busy, 2'b01);
    check("coll busy_vec6", m_if.busy_vec[6], 1'b1);

    // Bypass on vs. off, same stimulus.
    drive_m(1'b1, 5'd3, 32'h1234, 5'd3, 5'd0, 1'b0, 5'd0);
    nb_if.wr_en = 1'b1; nb_if.wr_addr = 5'd3; nb_if.wr_data = 32'h1234;
    nb_if.rd_addr = {5'd0, 5'd3};
    settle();
    check("byp on rd_data", m_if.rd_data[31:0], 32'h1234);
    check("byp off rd_data", nb_if.rd_data[31:0], 32'h0);
    tick();
    drive_m(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0);
    nb_if.wr_en = 1'b0;
    settle();
    check("byp on next rd_data", m_if.rd_data[31:0], 32'h1234);
    check("byp off next rd_data", nb_if.rd_data[31:0], 32'h1234);

    // Register 0 as an ordinary register.
    nz_if.wr_en = 1'b1; nz_if.wr_addr = 5'd0; nz_if.wr_data = 32'hFFFF;
    nz_if.claim_en = 1'b1; nz_if.claim_addr = 5'd0; nz_if.rd_addr = '0;
    settle();
    check("nozero claim_ok", nz_if.claim_ok, 1'b1);
    tick();
    nz_if.wr_en = 1'b0; nz_if.claim_en = 1'b0;
    settle();
    check("nozero rd_data", nz_if.rd_data[31:0], 32'hFFFF);
    check("nozero rd_busy", nz_if.rd_busy[0], 1'b1);
    check("nozero busy_vec0", nz_if.busy_vec[0], 1'b1);

    // Narrow 3-port build.
    s_if.wr_en = 1'b1; s_if.wr_addr = 3'd1; s_if.wr_data = 16'h0101;
    tick();
    s_if.wr_addr = 3'd2; s_if.wr_data = 16'h0202;
    tick();
    s_if.wr_addr = 3'd7; s_if.wr_data = 16'h0707;
    tick();
    s_if.wr_en = 1'b0;
    s_if.rd_addr = {3'd7, 3'd2, 3'd1};
    s_if.claim_en = 1'b1; s_if.claim_addr = 3'd7;
    settle();
    check("small rd_data", s_if.rd_data, {16'h0707, 16'h0202, 16'h0101});
    check("small claim_ok", s_if.claim_ok, 1'b1);
    tick();
    s_if.claim_en = 1'b0;
    settle();
    check("small busy_vec", s_if.busy_vec, 8'h80);
    check("small rd_busy", s_if.rd_busy, 3'b100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
